spi_reg_bridge: RTL

//  Bridges the external SPI link from the host MCU to the internal control-register bus.

---
 rtl/spi_reg_bridge.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bridge.sv
// SPI (mode 0) slave that turns one command+data frame per chip-select window
// into a single-cycle write strobe on the internal control-register bus.
module spi_reg_bridge #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              csN,
  output logic [ADDR_W-1:0] aBus,
  output logic [DATA_W-1:0] dBus,
  output logic              wrEnable,
  output logic              frameErr
);

  localparam int CNT_MAX = (DATA_W > 8) ? DATA_W : 8;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;
  logic                   r_armed;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_cmd_w;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_data;

  logic              w_sclk_rise;
  logic              w_mosi;
  logic              w_cs_high;
  logic              w_cs_fall;
  logic [DATA_W-1:0] w_data_full;
  logic              w_cmd_shift;
  logic              w_data_shift;
  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic              w_commit;
  logic              w_abort;

  assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_high   = r_cs_sync[SYNC_STAGES-1];
  assign w_cs_fall   = r_cs_prev & ~r_cs_sync[SYNC_STAGES-1];
  assign w_data_full = DATA_W'({r_data, w_mosi});

  // Synchronizers and edge-detect history; cleared low so csN must be seen high before arming
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= SYNC_STAGES'({r_sclk_sync, sclk});
      r_mosi_sync <= SYNC_STAGES'({r_mosi_sync, mosi});
      r_cs_sync   <= SYNC_STAGES'({r_cs_sync, csN});
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
      r_armed     <= r_armed | w_cs_high;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and datapath controls; last-bit completion outranks a same-cycle csN rise
  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_shift  = 1'b0;
    w_data_shift = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_commit     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall && r_armed) begin
          w_state_nxt = ST_CMD;
          w_cnt_clr   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (w_cs_high) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end else if (w_sclk_rise) begin
          w_cmd_shift = 1'b1;
          if (r_bit_cnt == CNT_W'(7)) begin
            w_state_nxt = ST_DATA;
            w_cnt_clr   = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end else begin
          w_state_nxt = ST_CMD;
        end
      end
      ST_DATA: begin
        if (w_sclk_rise && (r_bit_cnt == CNT_W'(DATA_W - 1))) begin
          w_state_nxt  = ST_DONE;
          w_data_shift = 1'b1;
          w_commit     = r_cmd_w;
        end else if (w_cs_high) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end else if (w_sclk_rise) begin
          w_data_shift = 1'b1;
          w_cnt_inc    = 1'b1;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DONE: begin
        if (w_cs_high) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bit counter (saturating) and frame shift registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bit_cnt <= '0;
      r_cmd_w   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      if (w_cnt_clr) begin
        r_bit_cnt <= '0;
      end else if (w_cnt_inc && (r_bit_cnt != CNT_W'(CNT_MAX))) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end else begin
        r_bit_cnt <= r_bit_cnt;
      end
      // The first command bit is W; the address is whatever remains in the low bits after 8 shifts
      if (w_cmd_shift) begin
        r_cmd_w <= (r_bit_cnt == CNT_W'(0)) ? w_mosi : r_cmd_w;
        r_addr  <= ADDR_W'({r_addr, w_mosi});
      end else begin
        r_cmd_w <= r_cmd_w;
        r_addr  <= r_addr;
      end
      if (w_data_shift) begin
        r_data <= w_data_full;
      end else begin
        r_data <= r_data;
      end
    end
  end

  // Registered bus outputs: commit one cycle after the final bit, abort pulse likewise
  always_ff @(posedge clk) begin
    if (!rst) begin
      aBus     <= '0;
      dBus     <= '0;
      wrEnable <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      if (w_commit) begin
        aBus <= r_addr;
        dBus <= w_data_full;
      end else begin
        aBus <= aBus;
        dBus <= dBus;
      end
      wrEnable <= w_commit;
      frameErr <= w_abort;
    end
  end

endmodule
